// File: rtl/mux_nway_arb_pkg.sv
// mux_arb_pkg: shared mode encodings for the N-way stream multiplexer.
package mux_arb_pkg;
   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;
endpackage

// File: rtl/mux_nway_arb_rr_pick.sv
// rr_pick: combinational round-robin picker (rotate, priority-encode, un-rotate).
module rr_pick #(
   parameter int WAYS  = 4,
   localparam int SEL_W = $clog2(WAYS)
) (
   input  logic [WAYS-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic             gnt_valid,
   output logic [SEL_W-1:0] gnt_idx
);
   logic [WAYS-1:0]  rot;
   logic [SEL_W-1:0] off;
   int               sum;
   always_comb begin
      rot = '0;
      for (int i = 0; i < WAYS; i++) rot[i] = req[(i + int'(ptr)) % WAYS];
      off = '0;
      for (int i = WAYS - 1; i >= 0; i--) if (rot[i]) off = SEL_W'(i);
      sum = int'(off) + int'(ptr);
      gnt_valid = |req;
      gnt_idx = SEL_W'(sum >= WAYS ? sum - WAYS : sum);
   end
endmodule

// File: rtl/mux_nway_arb.sv
// mux_nway_arb: N-way W-bit stream mux with registered output, fixed or round-robin channel choice.
module mux_nway_arb
   import mux_arb_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int WAYS  = 4,
   localparam int SEL_W = $clog2(WAYS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      sel,
   input  logic [WAYS-1:0]       in_valid,
   output logic [WAYS-1:0]       in_ready,
   input  logic [WAYS*WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [SEL_W-1:0]      out_chan
);
   logic [SEL_W-1:0] ptr, rr_idx, g;
   logic             rr_valid, fix_valid, gnt_valid, free, take;
   rr_pick #(.WAYS(WAYS)) u_pick (
      .req      (in_valid),
      .ptr      (ptr),
      .gnt_valid(rr_valid),
      .gnt_idx  (rr_idx)
   );
   // sel values past the last channel never grant, guarding non-power-of-two WAYS
   assign fix_valid = (int'(sel) < WAYS) ? in_valid[sel] : 1'b0;
   assign gnt_valid = (mode == MODE_RR) ? rr_valid : fix_valid;
   assign g         = (mode == MODE_RR) ? rr_idx : sel;
   assign free      = !out_valid || out_ready;
   assign take      = free && gnt_valid && !reset;
   assign in_ready  = take ? (WAYS'(1) << g) : '0;
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         ptr       <= '0;
      end else if (free) begin
         out_valid <= gnt_valid;
         if (gnt_valid) begin
            out_data <= in_data[int'(g)*WIDTH +: WIDTH];
            out_chan <= g;
            if (mode == MODE_RR) ptr <= (int'(g) == WAYS - 1) ? '0 : g + SEL_W'(1);
         end
      end
   end
endmodule

// File: doc/mux_nway_arb.md
# mux_nway_arb

Parametrised N-way, W-bit stream multiplexer with a registered output and valid/ready handshakes on every channel. It is the sequential successor to the combinational 4-way 16-bit mux: channel count and width are parameters, and channel choice is either software-fixed (`sel`) or round-robin among requesting channels. It sits between multiple producers and one consumer on the data path, for example multiple sources feeding a shared bus or RAM write port.

## Interface
Parameters:
- `WIDTH`, 16: data width per channel, ≥1.
- `WAYS`, 4: number of input channels, ≥2.
- `SEL_W`, localparam, `$clog2(WAYS)`: channel-index width.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `mode`, in, 1: 0 = fixed select, 1 = round-robin.
- `sel`, in, `SEL_W`: channel index used in fixed mode; ignored in round-robin mode.
- `in_valid`, in, `WAYS`: per-channel valid.
- `in_ready`, out, `WAYS`: per-channel ready; combinational; at most one bit set.
- `in_data`, in, `WAYS*WIDTH`: channel k occupies bits `[k*WIDTH +: WIDTH]`.
- `out_valid`, out, 1: output register holds a word.
- `out_ready`, in, 1: consumer accepts the output word.
- `out_data`, out, `WIDTH`: registered data.
- `out_chan`, out, `SEL_W`: index of the channel that supplied `out_data`.

## Operation
- Internal state consists of the output register (`out_valid`, `out_data`, `out_chan`) and the round-robin pointer `ptr` (`SEL_W` bits).
- `free = !out_valid || out_ready`. The output register can load only when `free` is 1.
- Grant selection, combinational, evaluated each cycle:
  - Fixed mode: grant channel `sel` if `in_valid[sel]`; otherwise no grant. Values of `sel` ≥ `WAYS` produce no grant.
  - Round-robin mode: grant the first set `in_valid` bit, scanning from `ptr` upward and wrapping from `WAYS-1` to 0. No grant if `in_valid` is 0.
- `in_ready[g] = free && grant==g && !reset`. All other `in_ready` bits are 0.
- On a transfer (`in_valid[g] && in_ready[g]`): `out_data <= in_data[g]`, `out_chan <= g`, `out_valid <= 1`.
- `free` with no grant: `out_valid <= 0`. `out_data` and `out_chan` hold their last values.
- Not `free` (`out_valid && !out_ready`): the output register holds. `out_data` and `out_chan` must stay stable.
- `ptr` updates only on a round-robin transfer: `ptr <= (g == WAYS-1) ? 0 : g+1`. A fixed-mode transfer leaves `ptr` unchanged.
- Changes to `mode` or `sel` take effect on the next grant evaluation. A word already held in the output register is unaffected.
- Simultaneous consume and accept (`out_valid && out_ready` with a grant): the old word leaves and the new word loads in the same edge. This is not a bubble.
- Reset mid-operation discards any held word and returns all state to its reset values. No transfer completes in a reset cycle.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_chan=0`, `ptr=0`. `in_ready` is all-zero while `reset` is high.
- Latency: 1 cycle. A word accepted at edge n appears with `out_valid=1` after edge n.
- Throughput: 1 word/cycle while `out_ready=1` and a grant exists.
- Combinational paths exist from `out_ready`, `in_valid`, `mode` and `sel` to `in_ready`. These are documented and intended; consumers must not create a loop back through them.
- Channels must hold `in_valid` and `in_data` until accepted. The block does not require this, but fairness guarantees assume it.
- Fairness in round-robin mode: a continuously valid channel is granted within `WAYS` transfers.

## Structure
- Package `mux_arb_pkg` holds:
  - `MODE_FIXED=1'b0` and `MODE_RR=1'b1`.
- Sub-module `rr_pick`: purely combinational.
  - Parameter: `WAYS`.
  - Inputs: `req[WAYS]`, `ptr`.
  - Outputs: `gnt_valid`, `gnt_idx`.
  - Implemented as a rotate, priority-encode, un-rotate sequence.
- The top level holds the output register, `ptr`, the mode mux between `sel` and `rr_pick`, and the `in_data` slice select.

## Test plan
All scenarios use `WAYS=4`, `WIDTH=16`, and channel data 1111/2222/3333/4444 hex for channels 0–3.
- Reset: hold `reset` for 2 cycles with all `in_valid=1`. Required: `in_ready=0000`, `out_valid=0`, `out_data=0000`, `out_chan=0`, then first transfer starts the cycle after release.
- Fixed mode: `mode=0`, `out_ready=1`, all valid, `sel=0,1,2,3` one per cycle. Required: `out_data=1111,2222,3333,4444` one cycle later each, with `out_chan` matching `sel`. Then `sel=2` with `in_valid=1011`. Required: no grant and `out_valid=0`.
- Round-robin wrap: `mode=1`, all valid, `out_ready=1` for 6 cycles. Required: `out_chan` sequence 0,1,2,3,0,1, and `ptr` wraps from 3 to 0.
- Round-robin skip: `in_valid=1010`, `ptr=0`. Required: grants go to channel 1, then 3, then 1.
- Backpressure: `out_valid=1` with `out_data=2222`, then `out_ready=0` for 3 cycles while new words are offered. Required: `in_ready=0000`, output stable at 2222. When `out_ready` rises, a back-to-back transfer follows with no bubble.
- Reset mid-stream: assert `reset` while `out_valid=1` and `ptr=2`. Required: the next cycle shows `out_valid=0` and `ptr=0`, and the next round-robin grant goes to channel 0.
